// File: rtl/serial_recover_pkg.sv
// Shared types and helpers for the bit-serial operand recovery block.
// Holds the FSM state type, default width and the serial borrow rule.
package serial_recover_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Borrow out of one subtractor bit: s - b - brw.
  function automatic logic brw_next(
    input logic s,
    input logic b,
    input logic brw
  );
    return (~s & b) | (~s & brw) | (b & brw);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = s - b - bin, bout = borrow out.
// Ports: s_i, b_i, bin_i in; d_o, bout_o out. Purely combinational.
module full_subtractor_cell
  import serial_recover_pkg::*;
(
  input  logic s_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = s_i ^ b_i ^ bin_i;
  assign bout_o = brw_next(s_i, b_i, bin_i);

endmodule

// File: rtl/serial_operand_recover.sv
// Recovers addend A = S - B - cin from LSB-first serial S/B beats.
// Ports: clk, rst_n; in_valid/in_ready/in_s/in_b/in_cin/in_last beat
// input; out_valid/out_ready/out_a/out_borrow/out_err word output.
module serial_operand_recover
  import serial_recover_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic             in_b,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             out_borrow,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             bo_q, bo_d;
  logic             err_q, err_d;

  logic beat;
  logic first;
  logic at_end;
  logic done;
  logic bin;
  logic cell_d;
  logic cell_bout;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_a      = a_q;
  assign out_borrow = bo_q;
  assign out_err    = err_q;

  assign beat   = in_valid & in_ready;
  assign first  = (cnt_q == '0);
  assign at_end = (cnt_q == LAST_K);
  assign done   = beat & (in_last | at_end);
  // Carry-in only matters on the first beat.
  assign bin    = first ? in_cin : brw_q;

  full_subtractor_cell u_cell (
    .s_i   (in_s),
    .b_i   (in_b),
    .bin_i (bin),
    .d_o   (cell_d),
    .bout_o(cell_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    sr_d    = sr_q;
    a_d     = a_q;
    bo_d    = bo_q;
    err_d   = err_q;
    unique case (state_q)
      COLLECT: begin
        if (beat) begin
          // Clearing on the first beat zeroes the
          // bits above an early in_last.
          if (first) sr_d = '0;
          sr_d[cnt_q] = cell_d;
          if (done) begin
            state_d = HOLD;
            cnt_d   = '0;
            brw_d   = 1'b0;
            a_d     = sr_d;
            bo_d    = cell_bout;
            err_d   = ~(in_last & at_end);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            brw_d = cell_bout;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      sr_q    <= '0;
      a_q     <= '0;
      bo_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      sr_q    <= sr_d;
      a_q     <= a_d;
      bo_q    <= bo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/serial_operand_recover.md
Name: serial_operand_recover

Overview:
- Bit-serial inverse of the team's ripple-carry adder benchmarks.
- Receives sum bits S and one addend's bits B LSB-first, plus the original carry-in, and reconstructs the other addend A = S − B − cin.
- Emits A as a parallel word with a borrow/overflow flag and a framing-error flag.
- Sits after the serial sum stream, as the checker/decoder stage used to verify adder outputs in the crossbar flow.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  serial beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_s  in  1  sum bit, LSB first.
- in_b  in  1  known-addend bit, LSB first.
- in_cin  in  1  original carry-in; sampled only on the first beat of a word.
- in_last  in  1  marks final beat of a word.
- out_valid  out  1  recovered word available.
- out_ready  in  1  downstream accepts word.
- out_a  out  WIDTH  recovered addend A.
- out_borrow  out  1  final borrow, i.e. the original addition carried out.
- out_err  out  1  framing error: in_last early, or missing on beat WIDTH-1.

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. While rst_n is low:
  - state=COLLECT, bit counter=0, borrow register=0, shift register=0;
  - in_ready=1 after release, out_valid=0, out_a=0, out_borrow=0, out_err=0.
- Reset mid-word or mid-HOLD discards all partial or pending data.
- States: COLLECT and HOLD (2-state FSM).
- COLLECT:
  - in_ready=1; out_valid=0.
  - A beat transfers when in_valid & in_ready.
  - On beat k (k=counter), the borrow input is in_cin if k==0, else the borrow register.
  - a_k = s ^ b ^ brw.
  - brw_next = (~s & b) | (~s & brw) | (b & brw).
  - a_k is stored at bit position k; counter increments.
- Word termination:
  - If in_last with k==WIDTH-1: normal end, err=0.
  - If in_last with k<WIDTH-1: early end, err=1; positions k+1..WIDTH-1 of out_a forced to 0; out_borrow = brw_next of beat k.
  - If k==WIDTH-1 without in_last: the word still ends, err=1.
  - On any termination, the next state is HOLD and the counter resets to 0.
- HOLD:
  - in_ready=0; out_valid=1; out_a/out_borrow/out_err stable until handshake.
  - out_valid & out_ready: next cycle returns to COLLECT with out_valid=0; outputs keep their last values.
  - No same-cycle input acceptance in HOLD. Throughput is WIDTH beats + 1 hold cycle minimum per word.
- Latency: out_valid rises in the cycle after the final beat transfers.
- in_valid low in COLLECT stalls the word; the counter and borrow register hold.
- in_cin on beats other than the first is ignored.
- Arithmetic is modulo 2^WIDTH; out_borrow=1 exactly when S+cout·2^WIDTH form had cout=1 (S < B+cin).

Decomposition:
- Shared package serial_recover_pkg holds:
  - the state typedef {COLLECT, HOLD};
  - the localparam for the default WIDTH;
  - the borrow function brw_next(s,b,brw).
- One combinational sub-module, full_subtractor_cell (s, b, bin -> d, bout), instantiated once and time-multiplexed across beats.

Test Plan:
- WIDTH=8, S=0x97, B=0x3C, cin=1, in_last on beat 7, out_ready=1 -> out_a=0x5A, out_borrow=0, out_err=0, out_valid one cycle after beat 7 for exactly 1 cycle.
- S=0x10, B=0x20, cin=0 -> out_a=0xF0, out_borrow=1, out_err=0.
- in_last on beat 2 with S bits 1,0,1, B bits 1,0,0, cin=0 -> out_a=0x04, out_borrow=0, out_err=1, returns to COLLECT.
- Word S=0xFF, B=0x00, cin=0 with in_valid toggling every other cycle, then out_ready held low 5 cycles -> out_a=0xFF; in_ready=0 and outputs stable throughout HOLD; next word accepted only after the handshake.
- rst_n pulsed low after beat 4 of a word, then clean word S=0x01, B=0x01, cin=0 -> no output from the partial word; second word gives out_a=0x00, out_borrow=0.
- 8 beats with no in_last, S=0x80, B=0x7F, cin=1 -> out_a=0x00, out_borrow=0, out_err=1.
